// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: fetch and debug ports share one single-port RAM.
// Round-robin grant, halt/drain handshake, one-cycle registered read data.
module imem_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_f_req,
  input  logic [12:0] i_f_addr,
  output logic        o_f_gnt,
  output logic        o_f_rvalid,
  output logic [31:0] o_f_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [12:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  input  logic        i_halt,
  output logic        o_halted,
  output logic [12:0] o_m_addr,
  output logic        o_m_we,
  output logic [31:0] o_m_wdata,
  input  logic [31:0] i_m_rdata
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        last_dbg_q;
  logic        f_rvalid_q;
  logic        d_rvalid_q;
  logic [31:0] f_rdata_q;
  logic [31:0] d_rdata_q;

  logic        d_mis;
  logic        d_ok;
  logic        f_ok;
  logic        f_gnt;
  logic        d_gnt;

  // Eligibility and round-robin grant; misaligned debug counts as idle.
  always_comb begin
    d_mis = 1'b0;
    d_ok  = 1'b0;
    f_ok  = 1'b0;
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!i_reset) begin
      d_mis = i_d_req && (i_d_addr[1:0] != 2'b00);
      d_ok  = i_d_req && (i_d_addr[1:0] == 2'b00);
      f_ok  = i_f_req && (state_q == RUN);
      f_gnt = f_ok && (!d_ok || last_dbg_q);
      d_gnt = d_ok && (!f_ok || !last_dbg_q);
    end
  end

  // Memory port driven by whichever side won; idle drives zeros.
  always_comb begin
    o_m_addr  = '0;
    o_m_we    = 1'b0;
    o_m_wdata = '0;
    if (f_gnt) begin
      o_m_addr = i_f_addr;
    end else if (d_gnt) begin
      o_m_addr  = i_d_addr;
      o_m_we    = i_d_we;
      o_m_wdata = i_d_wdata;
    end
  end

  // Halt sequencing: a granted fetch finishes before HALT is reported.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (i_halt) state_d = DRAIN;
      DRAIN:   if (!f_gnt) state_d = HALT;
      HALT:    if (!i_halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State, last-grant and read-data capture registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= RUN;
      last_dbg_q <= 1'b1;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= f_gnt;
      d_rvalid_q <= d_gnt && !i_d_we;
      if (f_gnt || d_gnt) last_dbg_q <= d_gnt;
      if (f_gnt) f_rdata_q <= i_m_rdata;
      if (d_gnt && !i_d_we) d_rdata_q <= i_m_rdata;
    end
  end

  assign o_f_gnt    = f_gnt;
  assign o_d_gnt    = d_gnt;
  assign o_d_err    = d_mis;
  assign o_f_rvalid = f_rvalid_q;
  assign o_d_rvalid = d_rvalid_q;
  assign o_f_rdata  = f_rdata_q;
  assign o_d_rdata  = d_rdata_q;
  assign o_halted   = (state_q == HALT);

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, halt/reset sequences,
// then random traffic against a cycle-level reference model.
module tb_imem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_f_req;
  logic [12:0] i_f_addr;
  logic        o_f_gnt;
  logic        o_f_rvalid;
  logic [31:0] o_f_rdata;
  logic        i_d_req;
  logic        i_d_we;
  logic [12:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic        o_d_gnt;
  logic        o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic        o_d_err;
  logic        i_halt;
  logic        o_halted;
  logic [12:0] o_m_addr;
  logic        o_m_we;
  logic [31:0] o_m_wdata;
  logic [31:0] i_m_rdata;

  always #5 i_clk = ~i_clk;

  imem_arbiter dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_f_req    (i_f_req),
    .i_f_addr   (i_f_addr),
    .o_f_gnt    (o_f_gnt),
    .o_f_rvalid (o_f_rvalid),
    .o_f_rdata  (o_f_rdata),
    .i_d_req    (i_d_req),
    .i_d_we     (i_d_we),
    .i_d_addr   (i_d_addr),
    .i_d_wdata  (i_d_wdata),
    .o_d_gnt    (o_d_gnt),
    .o_d_rvalid (o_d_rvalid),
    .o_d_rdata  (o_d_rdata),
    .o_d_err    (o_d_err),
    .i_halt     (i_halt),
    .o_halted   (o_halted),
    .o_m_addr   (o_m_addr),
    .o_m_we     (o_m_we),
    .o_m_wdata  (o_m_wdata),
    .i_m_rdata  (i_m_rdata)
  );

  function automatic logic [31:0] pat(int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'(i) * 32'h9E3779B1;
  endfunction

  // Environment RAM: combinational read, write on rising edge.
  logic [31:0] mem [0:2047];
  logic        mem_init;
  always @(posedge i_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
    end else if (o_m_we) begin
      mem[o_m_addr[12:2]] <= o_m_wdata;
    end
  end
  assign i_m_rdata = mem[o_m_addr[12:2]];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic rst, input logic fr,
                       input logic [12:0] fa, input logic dr,
                       input logic dw, input logic [12:0] da,
                       input logic [31:0] dd, input logic h);
    i_reset   = rst;
    i_f_req   = fr;
    i_f_addr  = fa;
    i_d_req   = dr;
    i_d_we    = dw;
    i_d_addr  = da;
    i_d_wdata = dd;
    i_halt    = h;
    #5;
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [115:0] outs();
    return {o_f_gnt, o_d_gnt, o_d_err, o_m_we, o_f_rvalid, o_d_rvalid,
            o_halted, o_m_addr, o_m_wdata, o_f_rdata, o_d_rdata};
  endfunction

  typedef struct {
    logic        rst, fr;
    logic [12:0] fa;
    logic        dr, dw;
    logic [12:0] da;
    logic [31:0] dd;
    logic        h;
    logic        fg, dg, de, we, frv, drv, hl;
    logic [12:0] ma;
    logic [31:0] wd, frd, drd;
  } vec_t;

  function automatic vec_t mk(int rst, int fr, int fa, int dr, int dw,
                              int da, int dd, int h, int fg, int dg,
                              int de, int we, int frv, int drv, int hl,
                              int ma, int wd, int frd, int drd);
    vec_t v;
    v.rst = 1'(rst); v.fr = 1'(fr); v.fa = 13'(fa);
    v.dr = 1'(dr); v.dw = 1'(dw); v.da = 13'(da);
    v.dd = 32'(dd); v.h = 1'(h);
    v.fg = 1'(fg); v.dg = 1'(dg); v.de = 1'(de); v.we = 1'(we);
    v.frv = 1'(frv); v.drv = 1'(drv); v.hl = 1'(hl);
    v.ma = 13'(ma); v.wd = 32'(wd);
    v.frd = 32'(frd); v.drd = 32'(drd);
    return v;
  endfunction

  localparam int B = 32'hDEADBEEF;
  localparam int C = 32'h12345678;

  vec_t        tbl [13];
  logic [31:0] ref_mem [0:2047];

  initial begin
    logic [115:0] ev;
    logic rst, fr, dr, dw, hlt;
    logic [12:0] fa, da;
    logic [31:0] dd;
    int   phase;
    logic last_dbg, m_frv, m_drv;
    logic [31:0] m_frd, m_drd;
    logic mis, dok, fok, eg, edg, ewe;
    logic [12:0] ema;
    logic [31:0] ewd;

    // rst fr fa dr dw da dd h | fg dg de we frv drv hl ma wd frd drd
    tbl[0]  = mk(1,1,'h010,1,0,'h010,0,0, 0,0,0,0,0,0,0, 0,0,0,0);
    tbl[1]  = mk(0,1,'h010,0,0,0,0,0,     1,0,0,0,0,0,0, 'h010,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,0,0,         0,0,0,0,1,0,0, 0,0,B,0);
    tbl[3]  = mk(1,0,0,0,0,0,0,0,         0,0,0,0,0,0,0, 0,0,B,0);
    tbl[4]  = mk(0,1,'h010,1,0,'h010,0,0, 1,0,0,0,0,0,0, 'h010,0,0,0);
    tbl[5]  = mk(0,1,'h010,1,0,'h010,0,0, 0,1,0,0,1,0,0, 'h010,0,B,0);
    tbl[6]  = mk(0,1,'h010,1,0,'h010,0,0, 1,0,0,0,0,1,0, 'h010,0,B,B);
    tbl[7]  = mk(0,1,'h010,1,0,'h010,0,0, 0,1,0,0,1,0,0, 'h010,0,B,B);
    tbl[8]  = mk(0,0,0,1,1,'h020,C,0,     0,1,0,1,0,1,0, 'h020,C,B,B);
    tbl[9]  = mk(0,1,'h020,0,0,0,0,0,     1,0,0,0,0,0,0, 'h020,0,B,B);
    tbl[10] = mk(0,1,'h010,1,0,'h006,0,0, 1,0,1,0,1,0,0, 'h010,0,C,B);
    tbl[11] = mk(0,0,0,1,1,'h022,'hFFFF,0,0,0,1,0,1,0,0, 0,0,B,B);
    tbl[12] = mk(0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0, 0,0,B,B);

    mem_init = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    mem_init = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].dw,
            tbl[i].da, tbl[i].dd, tbl[i].h);
      ev = {tbl[i].fg, tbl[i].dg, tbl[i].de, tbl[i].we, tbl[i].frv,
            tbl[i].drv, tbl[i].hl, tbl[i].ma, tbl[i].wd, tbl[i].frd,
            tbl[i].drd};
      chk($sformatf("vec%0d", i), 128'(outs()), 128'(ev));
      tick;
    end

    // Halt, drain, debug access while halted, resume.
    drive(0, 1, 13'h010, 0, 0, 0, 0, 0);
    chk("halt_pre_fg", 128'(o_f_gnt), 128'(1));
    tick;
    drive(0, 1, 13'h010, 0, 0, 0, 0, 1);
    chk("halt_req_fg", 128'(o_f_gnt), 128'(1));
    tick;
    drive(0, 1, 13'h010, 0, 0, 0, 0, 1);
    chk("drain_fg", 128'(o_f_gnt), 128'(0));
    chk("drain_halted", 128'(o_halted), 128'(0));
    tick;
    drive(0, 1, 13'h010, 1, 0, 13'h020, 0, 1);
    chk("halted", 128'(o_halted), 128'(1));
    chk("halt_gnts", 128'({o_f_gnt, o_d_gnt}), 128'(2'b01));
    tick;
    drive(0, 1, 13'h010, 0, 0, 0, 0, 1);
    chk("halt_drd", 128'({o_d_rvalid, o_d_rdata}), 128'({1'b1, 32'h12345678}));
    chk("halt_fg", 128'(o_f_gnt), 128'(0));
    tick;
    drive(0, 1, 13'h010, 0, 0, 0, 0, 0);
    chk("unhalt_cycle", 128'({o_halted, o_f_gnt}), 128'(2'b10));
    tick;
    drive(0, 1, 13'h010, 0, 0, 0, 0, 0);
    chk("resume", 128'({o_halted, o_f_gnt}), 128'(2'b01));
    tick;

    // Reset right after a fetch grant, from DRAIN.
    drive(0, 1, 13'h010, 0, 0, 0, 0, 1);
    chk("rst_pre_fg", 128'(o_f_gnt), 128'(1));
    tick;
    drive(1, 1, 13'h010, 1, 0, 13'h006, 0, 1);
    chk("rst_quiet", 128'({o_f_gnt, o_d_gnt, o_m_we, o_d_err}), 128'(0));
    tick;
    drive(0, 1, 13'h010, 0, 0, 0, 0, 1);
    chk("rst_after",
        128'({o_f_gnt, o_f_rvalid, o_halted, o_f_rdata}),
        128'({1'b1, 1'b0, 1'b0, 32'h0}));
    tick;

    // Random traffic against the reference model.
    mem_init = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);
    tick;
    mem_init = 1'b0;
    phase = 0;
    last_dbg = 1'b1;
    m_frv = 1'b0;
    m_drv = 1'b0;
    m_frd = '0;
    m_drd = '0;
    hlt = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      fr = 1'($urandom_range(0, 1));
      fa = 13'($urandom);
      dr = 1'($urandom_range(0, 1));
      dw = ($urandom_range(0, 2) == 0);
      da = 13'($urandom);
      if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
      dd = $urandom;
      if ($urandom_range(0, 7) == 0) hlt = ~hlt;
      drive(rst, fr, fa, dr, dw, da, dd, hlt);

      mis = !rst && dr && (da[1:0] != 2'b00);
      dok = !rst && dr && (da[1:0] == 2'b00);
      fok = !rst && fr && (phase == 0);
      if (fok && dok) begin
        eg  = last_dbg;
        edg = !last_dbg;
      end else begin
        eg  = fok;
        edg = dok;
      end
      ema = eg ? fa : (edg ? da : 13'h0);
      ewe = edg && dw;
      ewd = edg ? dd : 32'h0;
      ev = {eg, edg, mis, ewe, m_frv, m_drv, (phase == 2), ema, ewd,
            m_frd, m_drd};
      chk($sformatf("rand%0d", n), 128'(outs()), 128'(ev));

      if (rst) begin
        phase = 0;
        last_dbg = 1'b1;
        m_frv = 1'b0;
        m_drv = 1'b0;
        m_frd = '0;
        m_drd = '0;
      end else begin
        if (eg) m_frd = ref_mem[fa[12:2]];
        m_frv = eg;
        if (edg && !dw) m_drd = ref_mem[da[12:2]];
        m_drv = edg && !dw;
        if (edg && dw) ref_mem[da[12:2]] = dd;
        if (eg || edg) last_dbg = edg;
        if (phase == 0) phase = hlt ? 1 : 0;
        else if (phase == 1) phase = 2;
        else phase = hlt ? 2 : 0;
      end
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have no parameters; word array fixed at 2048 x 32, byte address 13 bits, word index = addr[12:2].
REQ-002 SHALL have i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have i_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have i_f_req, input, 1, fetch-stage read request.
REQ-005 SHALL have i_f_addr, input, 13, fetch byte address.
REQ-006 SHALL have o_f_gnt, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have o_f_rvalid, output, 1, fetch read data valid.
REQ-008 SHALL have o_f_rdata, output, 32, fetch read data.
REQ-009 SHALL have i_d_req, input, 1, debug/loader request.
REQ-010 SHALL have i_d_we, input, 1, debug write (1) or read (0).
REQ-011 SHALL have i_d_addr, input, 13, debug byte address.
REQ-012 SHALL have i_d_wdata, input, 32, debug write data.
REQ-013 SHALL have o_d_gnt, output, 1, debug request accepted this cycle.
REQ-014 SHALL have o_d_rvalid, output, 1, debug read data valid.
REQ-015 SHALL have o_d_rdata, output, 32, debug read data.
REQ-016 SHALL have o_d_err, output, 1, one-cycle pulse: debug request rejected (misaligned).
REQ-017 SHALL have i_halt, input, 1, level request to halt fetch.
REQ-018 SHALL have o_halted, output, 1, fetch port quiesced.
REQ-019 SHALL have o_m_addr, output, 13, memory byte address.
REQ-020 SHALL have o_m_we, output, 1, memory write strobe (memory writes on rising edge).
REQ-021 SHALL have o_m_wdata, output, 32, memory write data.
REQ-022 SHALL have i_m_rdata, input, 32, memory combinational read data for o_m_addr.

Function
REQ-023 SHALL run an FSM with states RUN, DRAIN, HALT.
REQ-024 RUN: both ports are eligible; on i_halt=1 -> DRAIN.
REQ-025 DRAIN: fetch is not granted; the state SHALL advance to HALT when no fetch read is outstanding (o_f_rvalid is not pending for the next cycle). DRAIN lasts at most 1 cycle.
REQ-026 HALT: o_halted=1 and only the debug port is eligible; on i_halt=0 -> RUN in the next cycle.
REQ-027 At most one grant per cycle; o_f_gnt and o_d_gnt SHALL never both be 1.
REQ-028 Arbitration is round-robin via a 1-bit last-grant register:
- if both ports are eligible and requesting, grant the port not granted last;
- if only one requests, grant it.
- last-grant updates only on a grant.
REQ-029 Grant is combinational in the request cycle; o_m_addr/o_m_we/o_m_wdata SHALL drive the granted port's values in the same cycle.
REQ-030 With no grant: o_m_we=0, o_m_addr=0, o_m_wdata=0.
REQ-031 A debug request with i_d_addr[1:0]!=0:
- SHALL NOT be granted and SHALL NOT touch memory;
- o_d_err pulses 1 in that cycle;
- the arbiter SHALL treat the debug port as not requesting, so a concurrent fetch may be granted.
REQ-032 Fetch addresses SHALL be forwarded unchecked; low bits are ignored by word indexing.
REQ-033 Read latency is exactly 1 cycle: i_m_rdata is registered on a granted read into the port's rdata register, and that port's rvalid is 1 in the following cycle only.
REQ-034 o_*_rdata SHALL hold the last captured value until the next read for that port.
REQ-035 A debug write is granted with o_m_we=1 and produces no rvalid.
REQ-036 Back-to-back grants to one port are allowed; each yields one rvalid.

Reset
REQ-037 On i_reset=1 at a clock edge: state=RUN, last-grant=debug (fetch wins first contention), rvalids=0, rdata registers=0, o_halted=0.
REQ-038 While i_reset=1, no grants SHALL be issued, o_m_we=0 and o_d_err=0.
REQ-039 Reset mid-operation SHALL discard any pending rvalid.

Verification
REQ-040 Preload word 4 = 0xDEADBEEF; fetch-only request to addr 0x010 -> o_f_gnt=1 that cycle; o_f_rvalid=1 with o_f_rdata=0xDEADBEEF next cycle.
REQ-041 Both ports request continuously for 4 cycles after reset -> grant sequence F,D,F,D; never both granted.
REQ-042 Debug write 0x12345678 to addr 0x020, then fetch read addr 0x020 -> o_f_rdata=0x12345678.
REQ-043 i_halt=1 while fetch requests continuously -> fetch grant stops next cycle; o_halted=1 within 2 cycles; a debug read during HALT completes; i_halt=0 -> fetch grants resume.
REQ-044 Debug request to addr 0x006 with concurrent fetch -> o_d_err=1, o_d_gnt=0, o_m_we=0, o_f_gnt=1.
REQ-045 Assert i_reset the cycle after a fetch grant -> o_f_rvalid=0, state RUN, no grants while reset=1.
